// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// operand width, iteration bound and the divide-by-zero quotient pattern.
package div_pkg;

  localparam int          DIV_WIDTH     = 32;
  localparam logic [4:0]  DIV_ITER_LAST = 5'd31;
  localparam logic [31:0] DIV_DBZ_QUOT  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div32_ctrl_if.sv
// Start/busy/done handshake and operand/result bus between a datapath
// (master) and the divider (slave).
interface div32_ctrl_if;
  import div_pkg::*;

  logic                 start;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 busy;
  logic                 done;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;
  logic                 div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div32_ctrl_sub32.sv
// 32-bit ripple-borrow subtractor: diff = a - b - bin, bout is the borrow
// out of the top bit cell.
module sub32
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] a,
  input  logic [DIV_WIDTH-1:0] b,
  input  logic                 bin,
  output logic                 bout,
  output logic [DIV_WIDTH-1:0] diff
);

  logic [DIV_WIDTH:0] borrow;

  assign borrow[0] = bin;

  generate
    for (genvar gi = 0; gi < DIV_WIDTH; gi++) begin : g_cell
      assign diff[gi]       = a[gi] ^ b[gi] ^ borrow[gi];
      assign borrow[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & borrow[gi]);
    end
  endgenerate

  assign bout = borrow[DIV_WIDTH];

endmodule

// File: rtl/div32_ctrl.sv
// Sequential unsigned restoring divider: one shift/trial-subtract step per
// clock through a single sub32, results held until the next accepted start.
module div32_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  div32_ctrl_if.slave  bus
);

  div_state_e state_reg, state_next;

  logic [WIDTH-1:0] p_reg, p_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] quot_reg, quot_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             dbz_reg, dbz_next;
  logic [4:0]       cnt_reg, cnt_next;

  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             sub_ok;

  assign trial = {p_reg[WIDTH-2:0], q_reg[WIDTH-1]};

  sub32 u_sub32 (
    .a    (trial),
    .b    (d_reg),
    .bin  (1'b0),
    .bout (borrow),
    .diff (diff)
  );

  // P[31] set means the true 33-bit trial value is >= 2^32 > D, so the
  // wrapped 32-bit difference is still the correct new remainder.
  assign sub_ok = p_reg[WIDTH-1] | ~borrow;

  always_comb begin
    state_next = state_reg;
    p_next     = p_reg;
    q_next     = q_reg;
    d_next     = d_reg;
    quot_next  = quot_reg;
    rem_next   = rem_reg;
    dbz_next   = dbz_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          q_next   = bus.dividend;
          d_next   = bus.divisor;
          p_next   = '0;
          cnt_next = '0;
          dbz_next = 1'b0;
          if (bus.divisor == '0) begin
            state_next = DONE;
            quot_next  = DIV_DBZ_QUOT;
            rem_next   = bus.dividend;
            dbz_next   = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end

      RUN: begin
        p_next   = sub_ok ? diff : trial;
        q_next   = {q_reg[WIDTH-2:0], sub_ok};
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == DIV_ITER_LAST) begin
          state_next = DONE;
          quot_next  = q_next;
          rem_next   = p_next;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      p_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      p_reg     <= p_next;
      q_reg     <= q_next;
      d_reg     <= d_next;
      quot_reg  <= quot_next;
      rem_reg   <= rem_next;
      dbz_reg   <= dbz_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign bus.busy        = (state_reg == RUN);
  assign bus.done        = (state_reg == DONE);
  assign bus.quotient    = quot_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div32_ctrl.sv
// Self-checking bench for div32_ctrl: directed table, hand-written corner
// sequences and randomized operands against an arithmetic reference model.
module tb_div32_ctrl;
  import div_pkg::*;

  logic clk;
  logic rst_n;

  div32_ctrl_if bus_if ();

  div32_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Caller is at a negedge; start is held for exactly one cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus_if.start    = 1'b1;
    bus_if.dividend = a;
    bus_if.divisor  = b;
    @(negedge clk);
    bus_if.start    = 1'b0;
    bus_if.dividend = $urandom;
    bus_if.divisor  = $urandom;
  endtask

  // Latency counts cycles from the start cycle to the done cycle.
  task automatic finish_op(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic ez,
                           input int inject);
    int lat;
    int busy_n;
    bit seen;
    lat    = 1;
    busy_n = 0;
    seen   = 0;
    while (lat <= 40) begin
      if (bus_if.busy) busy_n++;
      if (bus_if.done) begin
        seen = 1;
        break;
      end
      if (lat == inject) begin
        bus_if.start    = 1'b1;
        bus_if.dividend = 32'd50;
        bus_if.divisor  = 32'd5;
      end else begin
        bus_if.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus_if.start = 1'b0;
    $display("op %s: %h / %h -> q=%h r=%h dbz=%0d lat=%0d busy=%0d",
             name, a, b, bus_if.quotient, bus_if.remainder, bus_if.div_by_zero, lat, busy_n);
    check({name, ".done_seen"}, 32'(seen), 32'd1);
    check({name, ".latency"}, 32'(lat), ez ? 32'd1 : 32'd33);
    check({name, ".busy_cycles"}, 32'(busy_n), ez ? 32'd0 : 32'd32);
    check({name, ".quotient"}, bus_if.quotient, eq);
    check({name, ".remainder"}, bus_if.remainder, er);
    check({name, ".dbz"}, 32'(bus_if.div_by_zero), 32'(ez));
    @(negedge clk);
    check({name, ".done_pulse"}, 32'(bus_if.done), 32'd0);
    check({name, ".quot_hold"}, bus_if.quotient, eq);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".busy"}, 32'(bus_if.busy), 32'd0);
    check({name, ".done"}, 32'(bus_if.done), 32'd0);
    check({name, ".quotient"}, bus_if.quotient, 32'd0);
    check({name, ".remainder"}, bus_if.remainder, 32'd0);
    check({name, ".dbz"}, 32'(bus_if.div_by_zero), 32'd0);
    check({name, ".state"}, 32'(dut.state_reg), 32'(IDLE));
  endtask

  initial begin
    logic [31:0] a, b, eq, er;
    logic        ez;
    int          done_n;

    checks = 0;
    errors = 0;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0};
    vecs[2] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[3] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[4] = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    vecs[5] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[6] = '{32'd0,          32'hFFFF_FFFF,  32'd0,          32'd0,          1'b0};

    rst_n           = 1'b0;
    bus_if.start    = 1'b0;
    bus_if.dividend = 32'd0;
    bus_if.divisor  = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].a, vecs[i].b);
      finish_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, -1);
    end

    // Start during RUN is dropped; start in the IDLE cycle after DONE is taken.
    issue(32'd100, 32'd7);
    finish_op("ignored_start", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10);
    issue(32'd50, 32'd5);
    finish_op("back_to_back", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, -1);

    // Reset in the middle of RUN discards the operation.
    issue(32'd100, 32'd7);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("mid_reset");
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.done) done_n++;
      @(negedge clk);
    end
    check("mid_reset.no_done", 32'(done_n), 32'd0);
    issue(32'd100, 32'd7);
    finish_op("after_reset", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 255);
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      ref_div(a, b, eq, er, ez);
      issue(a, b);
      finish_op($sformatf("rand%0d", i), a, b, eq, er, ez, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
